// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg -- shared definitions for the seven-segment frame decoder.
//
// Contents:
//   CNT_W      width of the input stability counter (saturates at 2**CNT_W-1)
//   state_e    publish FSM states (SETTLE, PEND)
//   SEG_CODES  16-entry hex glyph table, active-high segments {a,b,c,d,e,f,g}
//   DP_EN      1 when decimal-point capture is compiled in
//
// Configuration macro: SEG_DP_CAPTURE_EN (defined -> DP bit is captured and
// takes part in frame comparison; undefined -> DP is ignored, o_dp tied low).
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,  // waiting for the inputs to hold still
        PEND   = 1'b1   // frame published, o_valid high until accepted
    } state_e;

    // Index k holds the lit segments for hex digit k; bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

`ifdef SEG_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

endpackage

// File: rtl/seg_if.sv
// -----------------------------------------------------------------------------
// seg_if -- one digit's decode bus.
//
// Signals:
//   pat    raw active-low pattern, bit7..1 = segments a..g, bit0 = DP
//   nib    decoded hex nibble (0 when blank or illegal)
//   blank  all segments a..g dark
//   err    pattern matches no hex glyph and is not blank
//   dp     decimal point lit (always 0 unless SEG_DP_CAPTURE_EN is defined)
//
// Modports:
//   master  supplies the pattern, consumes the decode results
//   slave   the decoder: takes the pattern, produces the results
// -----------------------------------------------------------------------------
interface seg_if;

    logic [7:0] pat;
    logic [3:0] nib;
    logic       blank;
    logic       err;
    logic       dp;

    modport master (output pat, input nib, blank, err, dp);
    modport slave  (input pat, output nib, blank, err, dp);

endinterface

// File: rtl/seg_digit_dec.sv
// -----------------------------------------------------------------------------
// seg_digit_dec -- purely combinational decode of one seven-segment digit.
//
// Ports:
//   dig  seg_if.slave  pattern in; nibble / blank / err / dp out
//
// Configuration macro: SEG_DP_CAPTURE_EN (via seg_pkg::DP_EN) enables dp.
// -----------------------------------------------------------------------------
module seg_digit_dec
    import seg_pkg::*;
(
    seg_if.slave dig
);

    logic [7:0] lit;     // active-high view of the pattern
    logic       hit;
    logic [3:0] idx;
    logic       blank_w;

    always_comb begin
        lit = ~dig.pat;
        hit = 1'b0;
        idx = 4'd0;
        // Table entries are unique, so at most one index can match.
        for (int k = 0; k < 16; k++) begin
            if (lit[7:1] == SEG_CODES[k]) begin
                hit = 1'b1;
                idx = 4'(k);
            end
        end
    end

    assign blank_w   = (lit[7:1] == 7'd0);
    assign dig.nib   = hit ? idx : 4'd0;
    assign dig.blank = blank_w;
    assign dig.err   = !hit && !blank_w;
    assign dig.dp    = lit[0] & DP_EN;

endmodule

// File: rtl/seg_decoder.sv
// -----------------------------------------------------------------------------
// seg_decoder -- debounced eight-digit seven-segment frame decoder.
//
// The 64 input bits are sampled every cycle; once the sample has held still
// for STABLE_CYCLES consecutive samples and differs from the frame published
// last, the decoded frame is published with o_valid.
//
// Parameters:
//   STABLE_CYCLES  identical samples needed before a frame counts (1..255)
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   i_seg0..i_seg7  active-low patterns, bit7..1 = a..g, bit0 = DP
//   o_val           decoded nibbles, digit n in [4n+3:4n]
//   o_blank         per-digit "all of a..g dark"
//   o_err           per-digit illegal pattern
//   o_dp            per-digit DP lit (0 unless SEG_DP_CAPTURE_EN)
//   o_valid         decoded frame available
//   i_ready         consumer accepts the frame
//
// Handshake: o_valid/i_ready are strict valid/ready. Once o_valid is high the
// frame outputs are frozen and o_valid stays high until a rising edge that
// sees o_valid && i_ready; o_valid then drops for at least one cycle. i_ready
// may be held high permanently.
//
// Configuration macro: SEG_DP_CAPTURE_EN (see seg_pkg).
// -----------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_seg0,
    input  logic [7:0]  i_seg1,
    input  logic [7:0]  i_seg2,
    input  logic [7:0]  i_seg3,
    input  logic [7:0]  i_seg4,
    input  logic [7:0]  i_seg5,
    input  logic [7:0]  i_seg6,
    input  logic [7:0]  i_seg7,
    output logic [31:0] o_val,
    output logic [7:0]  o_blank,
    output logic [7:0]  o_err,
    output logic [7:0]  o_dp,
    output logic        o_valid,
    input  logic        i_ready
);

    // With DP capture off the DP bit is dropped before it reaches the
    // snapshot, so it can neither reset the counter nor make a frame "new".
    localparam logic [63:0]      CMP_MASK = DP_EN ? {8{8'hFF}} : {8{8'hFE}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(STABLE_CYCLES - 1);

    logic [63:0]      sample;
    logic [63:0]      snap_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sample = {i_seg7, i_seg6, i_seg5, i_seg4,
                     i_seg3, i_seg2, i_seg1, i_seg0} & CMP_MASK;

    // ---------------------------------------------------------------- sampler
    always_comb begin
        cnt_d = cnt_q;
        if (sample != snap_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            snap_q <= sample;
            cnt_q  <= cnt_d;
        end
    end

    // ---------------------------------------------------------- digit decode
    logic [31:0] dec_val;
    logic [7:0]  dec_blank;
    logic [7:0]  dec_err;
    logic [7:0]  dec_dp;

    for (genvar g = 0; g < 8; g++) begin : g_dig
        seg_if u_bus ();

        assign u_bus.pat = snap_q[8*g +: 8];

        seg_digit_dec u_dec (
            .dig (u_bus.slave)
        );

        assign dec_val[4*g +: 4] = u_bus.nib;
        assign dec_blank[g]      = u_bus.blank;
        assign dec_err[g]        = u_bus.err;
        assign dec_dp[g]         = u_bus.dp;
    end

    // ------------------------------------------------------------ publish FSM
    state_e      state_q, state_d;
    logic [63:0] pub_q;       // snapshot of the last published frame
    logic        pub_ok_q;    // pub_q holds a real frame (cleared by reset)
    logic        fresh;
    logic        publish;

    // The counter keeps running in PEND, so a frame that settled while the
    // consumer was stalled already satisfies the threshold on return.
    assign fresh = (cnt_q >= CNT_THR) && (!pub_ok_q || (snap_q != pub_q));

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        case (state_q)
            SETTLE: begin
                if (fresh) begin
                    state_d = PEND;
                    publish = 1'b1;
                end
            end
            PEND: begin
                if (i_ready) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    logic [31:0] val_q;
    logic [7:0]  blank_q;
    logic [7:0]  err_q;
    logic [7:0]  dp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SETTLE;
            pub_q    <= '0;
            pub_ok_q <= 1'b0;
            val_q    <= '0;
            blank_q  <= 8'hFF;
            err_q    <= '0;
            dp_q     <= '0;
        end else begin
            state_q <= state_d;
            if (publish) begin
                pub_q    <= snap_q;
                pub_ok_q <= 1'b1;
                val_q    <= dec_val;
                blank_q  <= dec_blank;
                err_q    <= dec_err;
                dp_q     <= dec_dp;
            end
        end
    end

    assign o_val   = val_q;
    assign o_blank = blank_q;
    assign o_err   = err_q;
    assign o_dp    = dp_q;
    assign o_valid = (state_q == PEND);

endmodule

// File: tb/tb_seg_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_decoder -- self-checking bench for seg_decoder.
//
// A frame-level model tracks how long the input word has held still and what
// was last published, and a compare process checks every DUT output against
// it on every falling edge. Directed scenarios add literal expectations, then
// a randomized phase exercises arbitrary frames, hold times, back-pressure
// and occasional resets.
// Configuration macro: SEG_DP_CAPTURE_EN (changes the DP expectations).
// -----------------------------------------------------------------------------
module tb_seg_decoder;

    localparam int STABLE = 4;

`ifdef SEG_DP_CAPTURE_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    // Raw active-low byte that shows hex digit k with the DP dark.
    localparam logic [7:0] GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  blank;
        logic [7:0]  err;
        logic [7:0]  dp;
    } frame_t;

    // ------------------------------------------------------ clock and reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  seg [8];
    logic [31:0] o_val;
    logic [7:0]  o_blank, o_err, o_dp;
    logic        o_valid;

    always #5 clk = ~clk;

    seg_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_seg0  (seg[0]),
        .i_seg1  (seg[1]),
        .i_seg2  (seg[2]),
        .i_seg3  (seg[3]),
        .i_seg4  (seg[4]),
        .i_seg5  (seg[5]),
        .i_seg6  (seg[6]),
        .i_seg7  (seg[7]),
        .o_val   (o_val),
        .o_blank (o_blank),
        .o_err   (o_err),
        .o_dp    (o_dp),
        .o_valid (o_valid),
        .i_ready (ready)
    );

    // Stand-alone digit decoder on its own interface for glyph-table checks.
    seg_if u_probe ();
    seg_digit_dec u_probe_dec (.dig(u_probe.slave));

    // ------------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    function automatic logic [63:0] cur_word();
        logic [63:0] w;
        for (int d = 0; d < 8; d++) begin
            w[8*d +: 8] = seg[d];
            if (!DP_ON) w[8*d] = 1'b0;
        end
        return w;
    endfunction

    function automatic frame_t decode_frame(input logic [63:0] w);
        frame_t f;
        f = '0;
        for (int d = 0; d < 8; d++) begin
            logic [7:0] b;
            logic       found;
            b     = w[8*d +: 8] | 8'h01;
            found = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (b == GLYPH[k]) begin
                    f.val[4*d +: 4] = 4'(k);
                    found = 1'b1;
                end
            end
            if (b == 8'hFF) f.blank[d] = 1'b1;
            else if (!found) f.err[d] = 1'b1;
            f.dp[d] = DP_ON & ~w[8*d];
        end
        return f;
    endfunction

    logic [63:0] run_val;      // value the inputs currently hold
    int          run_len;      // how many consecutive samples it has held
    logic [63:0] m_pub;
    bit          m_pub_ok   = 1'b0;
    bit          m_pend     = 1'b0;
    bit          model_live = 1'b0;
    frame_t      exp_f;

    task automatic step_model();
        logic [63:0] smp;
        smp = cur_word();
        if (rst) begin
            run_val    = '0;
            run_len    = 1;
            m_pend     = 1'b0;
            m_pub_ok   = 1'b0;
            exp_f      = '{val: 32'h0, blank: 8'hFF, err: 8'h0, dp: 8'h0};
            model_live = 1'b1;
        end else begin
            if (m_pend) begin
                if (ready) m_pend = 1'b0;
            end else if (run_len >= STABLE && (!m_pub_ok || run_val != m_pub)) begin
                m_pend   = 1'b1;
                m_pub    = run_val;
                m_pub_ok = 1'b1;
                exp_f    = decode_frame(run_val);
            end
            if (smp == run_val) begin
                run_len++;
            end else begin
                run_val = smp;
                run_len = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            step_model();
        end
    end

    // --------------------------------------------------------- compare process
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("cyc_valid", 64'(o_valid), 64'(m_pend));
                chk("cyc_val",   64'(o_val),   64'(exp_f.val));
                chk("cyc_blank", 64'(o_blank), 64'(exp_f.blank));
                chk("cyc_err",   64'(o_err),   64'(exp_f.err));
                chk("cyc_dp",    64'(o_dp),    64'(exp_f.dp));
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic set_all(input logic [7:0] b);
        for (int d = 0; d < 8; d++) seg[d] = b;
    endtask

    // Watch a bounded number of falling edges; report the first cycle o_valid
    // was seen high, the number of rising o_valid edges and the first frame.
    task automatic watch(input int cycles, output int first, output int pulses,
                         output frame_t got);
        logic prev;
        first  = 0;
        pulses = 0;
        got    = '0;
        prev   = o_valid;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (o_valid && !prev) pulses++;
            if (o_valid && first == 0) begin
                first = k;
                got   = {o_val, o_blank, o_err, o_dp};
            end
            prev = o_valid;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        case ($urandom_range(0, 9))
            0, 1:    b = 8'hFF;
            2, 3:    b = 8'($urandom_range(0, 255));
            default: begin
                b = GLYPH[$urandom_range(0, 15)];
                if ($urandom_range(0, 3) == 0) b[0] = 1'b0;
            end
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------- stimulus
    initial begin
        int     first, pulses, acc;
        frame_t got;

        set_all(8'hFF);

        // Glyph table pinned through a stand-alone decoder.
        for (int k = 0; k < 16; k++) begin
            u_probe.pat = GLYPH[k];
            #1;
            chk("probe_nib", 64'(u_probe.nib), 64'(k));
            chk("probe_ok",  64'({u_probe.blank, u_probe.err}), 64'(0));
        end
        u_probe.pat = 8'hFF; #1;
        chk("probe_blank", 64'({u_probe.nib, u_probe.blank, u_probe.err}), 64'(6'b0000_10));
        u_probe.pat = 8'hAA; #1;
        chk("probe_err", 64'({u_probe.nib, u_probe.blank, u_probe.err}), 64'(6'b0000_01));
        u_probe.pat = 8'h02; #1;
        chk("probe_dp", 64'(u_probe.dp), 64'(DP_ON));

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_val",   64'(o_val),   64'(32'h0));
        chk("rst_blank", 64'(o_blank), 64'(8'hFF));
        chk("rst_err",   64'({o_err, o_dp}), 64'(16'h0));
        chk("rst_valid", 64'(o_valid), 64'(0));

        // "3" and "1" on digits 0/1, rest blank: o_valid on the 5th edge.
        rst = 1'b0;
        seg[0] = 8'h0D;
        seg[1] = 8'h9F;
        watch(10, first, pulses, got);
        chk("first_latency", 64'(first), 64'(STABLE + 1));
        chk("first_pulses",  64'(pulses), 64'(1));
        chk("first_val",     64'(got.val), 64'(32'h0000_0013));
        chk("first_blank",   64'(got.blank), 64'(8'hFC));
        chk("first_err",     64'(got.err), 64'(8'h00));

        // Digit 2 chatters every 2 cycles, then settles on "0".
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            seg[2] = (i % 2 == 1) ? 8'h9F : 8'h03;
            watch(2, first, pulses, got);
            acc += pulses;
        end
        chk("chatter_quiet", 64'(acc), 64'(0));
        seg[2] = 8'h03;
        watch(12, first, pulses, got);
        chk("settle_pulses", 64'(pulses), 64'(1));
        chk("settle_val",    64'(got.val), 64'(32'h0000_0013));
        chk("settle_blank",  64'(got.blank), 64'(8'hF8));

        // Illegal pattern on digit 5 only.
        seg[5] = 8'hAA;
        watch(12, first, pulses, got);
        chk("illegal_pulses", 64'(pulses), 64'(1));
        chk("illegal_err",    64'(got.err), 64'(8'h20));
        chk("illegal_val",    64'(got.val), 64'(32'h0000_0013));
        chk("illegal_blank",  64'(got.blank), 64'(8'hD8));

        // Consumer stalls: frame A held while frame B settles behind it.
        ready = 1'b0;
        set_all(8'h01);
        watch(12, first, pulses, got);
        chk("stall_a_val", 64'(got.val), 64'(32'h8888_8888));
        for (int d = 0; d < 8; d++) seg[d] = GLYPH[d];
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!o_valid || o_val != 32'h8888_8888) acc++;
        end
        chk("stall_held", 64'(acc), 64'(0));
        ready = 1'b1;
        @(negedge clk);
        chk("stall_gap", 64'(o_valid), 64'(0));
        ready = 1'b0;
        @(negedge clk);
        chk("stall_b_valid", 64'(o_valid), 64'(1));
        chk("stall_b_val",   64'(o_val), 64'(32'h7654_3210));
        chk("stall_b_blank", 64'({o_blank, o_err}), 64'(16'h0));

        // Reset while B is still pending.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(o_valid), 64'(0));
        chk("midrst_val",   64'(o_val), 64'(32'h0));
        chk("midrst_blank", 64'(o_blank), 64'(8'hFF));
        rst = 1'b0;
        watch(10, first, pulses, got);
        chk("repub_latency", 64'(first), 64'(STABLE + 1));
        chk("repub_val",     64'(got.val), 64'(32'h7654_3210));

        // Only the DP of digit 0 changes on an accepted, stable frame.
        ready = 1'b1;
        repeat (4) @(negedge clk);
        seg[0] = 8'h02;
        watch(15, first, pulses, got);
        chk("dp_only_on",  64'(pulses), 64'(DP_ON));
        seg[0] = 8'h03;
        watch(15, first, pulses, got);
        chk("dp_only_off", 64'(pulses), 64'(DP_ON));

        // Randomized frames, hold times, back-pressure and rare resets.
        for (int c = 0; c < 3000;) begin
            int nm, hold;
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) seg[$urandom_range(0, 7)] = rand_byte();
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                ready = ($urandom_range(0, 3) != 0);
                rst   = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
            c += hold;
        end
        rst   = 1'b0;
        ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
